// File: rtl/dm_loader_pkg.sv
// Shared types and constants for the UART-to-data-memory loader.
// Holds the loader FSM state encoding and the memory geometry.
package dm_loader_pkg;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 13;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    WR   = 2'd3
  } load_state_e;

endpackage : dm_loader_pkg

// File: rtl/dm_port_mux.sv
// Combinational owner select for the single data-memory port.
// A memory-side master either owns the port or the CPU request passes through untouched.
module dm_port_mux #(
  parameter int ADDR_W = dm_loader_pkg::ADDR_W,
  parameter int DATA_W = 2 * dm_loader_pkg::BYTE_W
) (
  input  logic              ldr_sel_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic              ldr_we_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic              dm_re_o,
  output logic              dm_we_o,
  output logic [DATA_W-1:0] dm_wdata_o
);

  // The loader only ever writes, so a selected loader forces the read strobe low.
  assign dm_addr_o  = ldr_sel_i ? ldr_addr_i  : cpu_addr_i;
  assign dm_re_o    = ldr_sel_i ? 1'b0        : cpu_re_i;
  assign dm_we_o    = ldr_sel_i ? ldr_we_i    : cpu_we_i;
  assign dm_wdata_o = ldr_sel_i ? ldr_wdata_i : cpu_wdata_i;

endmodule : dm_port_mux

// File: rtl/dm_uart_loader.sv
// Bulk loader: packs UART byte pairs high-byte-first into words and writes them to
// consecutive data-memory addresses from a base, stalling the CPU while it owns the port.
module dm_uart_loader #(
  parameter int DEPTH  = dm_loader_pkg::DEPTH,
  parameter int ADDR_W = dm_loader_pkg::ADDR_W,
  parameter int DATA_W = 2 * dm_loader_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              clr_rdy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wrt_data,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wrt_data,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done
);

  import dm_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              ldr_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every target gets a hold/default value first so no path through the
  // case leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = base_addr;
            remain_d = word_cnt;
            state_d  = HI;
          end
        end
      end
      HI: begin
        if (rx_rdy) begin
          hi_d    = rx_data;
          state_d = LO;
        end
      end
      LO: begin
        if (rx_rdy) begin
          lo_d    = rx_data;
          state_d = WR;
        end
      end
      WR: begin
        remain_d = remain_q - 1'b1;
        addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        if (remain_q == ADDR_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // clr_rdy is held low during reset so the UART never loses a byte the FSM drops.
  always_comb begin
    busy      = (state_q != IDLE);
    cpu_stall = busy;
    ldr_we    = (state_q == WR);
    done      = done_q;
    clr_rdy   = rst_n && ((state_q == HI) || (state_q == LO)) && rx_rdy;
  end

  dm_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .ldr_sel_i   (busy),
    .cpu_addr_i  (cpu_addr),
    .cpu_re_i    (cpu_re),
    .cpu_we_i    (cpu_we),
    .cpu_wdata_i (cpu_wrt_data),
    .ldr_addr_i  (addr_q),
    .ldr_we_i    (ldr_we),
    .ldr_wdata_i ({hi_q, lo_q}),
    .dm_addr_o   (dm_addr),
    .dm_re_o     (dm_re),
    .dm_we_o     (dm_we),
    .dm_wdata_o  (dm_wrt_data)
  );

endmodule : dm_uart_loader

// File: tb/tb_dm_uart_loader.sv
// Self-checking bench for dm_uart_loader: a negedge memory model logs every write,
// and each scenario compares that log against a queue of expected writes.
module tb_dm_uart_loader;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] base_addr;
  logic [12:0] word_cnt;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic [12:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wrt_data;
  logic [12:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_wrt_data;
  logic        cpu_stall;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Monitor-owned state
  int    cyc      = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    clr_cnt  = 0;
  int    busy_cnt = 0;
  int    we_cnt   = 0;
  int    viol_cnt = 0;
  wr_t   wr_log[$];
  logic [15:0] mem [0:2047];

  // Scoreboard state owned by the test sequence
  wr_t exp_q[$];
  int  wr_rd = 0;

  dm_uart_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .word_cnt     (word_cnt),
    .rx_data      (rx_data),
    .rx_rdy       (rx_rdy),
    .clr_rdy      (clr_rdy),
    .cpu_addr     (cpu_addr),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_wrt_data (cpu_wrt_data),
    .dm_addr      (dm_addr),
    .dm_re        (dm_re),
    .dm_we        (dm_we),
    .dm_wrt_data  (dm_wrt_data),
    .cpu_stall    (cpu_stall),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and event counters, sampled where the memory samples.
  always @(negedge clk) begin
    if (dm_we === 1'b1) begin
      mem[dm_addr[10:0]] <= dm_wrt_data;
      wr_log.push_back({dm_addr, dm_wrt_data});
      we_cnt <= we_cnt + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (clr_rdy === 1'b1) clr_cnt <= clr_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if ((busy === 1'b1 && (dm_re !== 1'b0 || (dm_re === 1'b1 && dm_we === 1'b1)))
        || cpu_stall !== busy)
      viol_cnt <= viol_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required all tests to finish");
    $fatal(1, "watchdog");
  end

  // Presents one byte until the DUT consumes it; returns just after a posedge.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok      = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (clr_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Starts a load, streams its bytes, pushes expected writes, waits for idle.
  task automatic run_load(input logic [12:0] base, input logic [12:0] cnt,
                          input logic [15:0] w[$], input int gap, input bit mid_start,
                          output int start_cyc, output int to_cnt);
    logic [12:0] a;
    int          tos;
    bit          idle_ok;
    a   = base;
    tos = 0;
    for (int i = 0; i < w.size(); i++) begin
      exp_q.push_back({a, w[i]});
      a = (a == 13'h7FF) ? 13'h000 : a + 13'd1;
    end
    start     = 1'b1;
    base_addr = base;
    word_cnt  = cnt;
    start_cyc = cyc;
    fork
      begin
        @(posedge clk);
        #1 start = 1'b0;
      end
      begin
        bit ok;
        for (int i = 0; i < w.size(); i++) begin
          send_byte(w[i][15:8], gap, ok);
          if (!ok) tos++;
          send_byte(w[i][7:0], gap, ok);
          if (!ok) tos++;
        end
      end
      begin
        if (mid_start) begin
          repeat (10) @(posedge clk);
          #1 start = 1'b1; base_addr = 13'h555; word_cnt = 13'd5;
          @(posedge clk);
          #1 start = 1'b0;
          repeat (30) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    idle_ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle_ok = 1'b1;
        break;
      end
    end
    if (!idle_ok) tos++;
    @(posedge clk);
    #1;
    to_cnt = tos;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b1; rx_data = 8'h5C;
    cpu_addr = 13'h0AB; cpu_re = 1'b1; cpu_we = 1'b0; cpu_wrt_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if (clr_rdy !== 1'b0) begin failures++; $display("FAIL reset_clr_rdy: got %b want 0", clr_rdy); end
    checks++; if (dm_addr !== 13'h0AB || dm_re !== 1'b1 || dm_we !== 1'b0)
      begin failures++; $display("FAIL reset_passthru: got addr=%h re=%b we=%b want 0ab/1/0", dm_addr, dm_re, dm_we); end
    rst_n = 1'b1; rx_rdy = 1'b0; cpu_re = 1'b0; cpu_addr = 13'h000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    int sc, to, d0;
    wr_t e;
    w.push_back(16'h1234); w.push_back(16'hABCD);
    d0 = done_cnt;
    run_load(13'h010, 13'd2, w, 0, 1'b0, sc, to);
    checks++; if (to != 0) begin failures++; $display("FAIL basic_timeout: got %0d timeouts want 0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL basic_write: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL basic_write: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
    checks++; if (wr_log.size() != wr_rd) begin failures++; $display("FAIL basic_extra_writes: got %0d want %0d", wr_log.size(), wr_rd); wr_rd = wr_log.size(); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (done_cyc - sc != 7) begin failures++; $display("FAIL basic_done_latency: got %0d want 7", done_cyc - sc); end
  endtask

  task automatic test_zero_count();
    int d0, b0, w0;
    d0 = done_cnt; b0 = busy_cnt; w0 = we_cnt;
    start = 1'b1; base_addr = 13'h050; word_cnt = 13'd0;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_next: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b want 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (busy_cnt != b0) begin failures++; $display("FAIL zero_busy_cycles: got %0d want 0", busy_cnt - b0); end
    checks++; if (we_cnt != w0) begin failures++; $display("FAIL zero_writes: got %0d want 0", we_cnt - w0); end
  endtask

  task automatic test_wrap();
    logic [15:0] w[$];
    int sc, to;
    wr_t e;
    w.push_back(16'h0F0F); w.push_back(16'hF0F0);
    run_load(13'h7FF, 13'd2, w, 0, 1'b0, sc, to);
    checks++; if (to != 0) begin failures++; $display("FAIL wrap_timeout: got %0d timeouts want 0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL wrap_write: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL wrap_write: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
    checks++; if (wr_log.size() != wr_rd) begin failures++; $display("FAIL wrap_extra_writes: got %0d want %0d", wr_log.size(), wr_rd); wr_rd = wr_log.size(); end
  endtask

  task automatic test_cpu_write();
    wr_t e;
    cpu_addr = 13'h020; cpu_wrt_data = 16'hBEEF; cpu_we = 1'b1;
    exp_q.push_back({13'h020, 16'hBEEF});
    @(negedge clk);
    checks++; if (dm_we !== 1'b1 || dm_addr !== 13'h020 || dm_wrt_data !== 16'hBEEF)
      begin failures++; $display("FAIL cpu_write_passthru: got we=%b %h@%h want 1 beef@020", dm_we, dm_wrt_data, dm_addr); end
    @(posedge clk);
    #1 cpu_we = 1'b0;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL cpu_write_mem: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL cpu_write_mem: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] w[$];
    int sc, to, v0, b0;
    wr_t e;
    w.push_back(16'h2468); w.push_back(16'h1357);
    cpu_addr = 13'h020; cpu_re = 1'b1;
    v0 = viol_cnt; b0 = busy_cnt;
    run_load(13'h040, 13'd2, w, 0, 1'b0, sc, to);
    checks++; if (to != 0) begin failures++; $display("FAIL stall_timeout: got %0d timeouts want 0", to); end
    checks++; if (viol_cnt != v0) begin failures++; $display("FAIL stall_dm_re_or_stall: got %0d bad cycles want 0", viol_cnt - v0); end
    checks++; if (busy_cnt - b0 != 6) begin failures++; $display("FAIL stall_busy_cycles: got %0d want 6", busy_cnt - b0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL stall_write: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL stall_write: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
    checks++; if (dm_re !== 1'b1 || dm_addr !== 13'h020)
      begin failures++; $display("FAIL stall_cpu_read_after: got re=%b addr=%h want 1/020", dm_re, dm_addr); end
    checks++; if (mem[dm_addr[10:0]] !== 16'hBEEF)
      begin failures++; $display("FAIL stall_read_data: got %h want beef", mem[dm_addr[10:0]]); end
    cpu_re = 1'b0; cpu_addr = 13'h000;
  endtask

  task automatic test_slow_uart();
    logic [15:0] w[$];
    int sc, to, c0, d0;
    wr_t e;
    w.push_back(16'h55AA); w.push_back(16'hC3E1);
    c0 = clr_cnt; d0 = done_cnt;
    run_load(13'h300, 13'd2, w, 20, 1'b1, sc, to);
    checks++; if (to != 0) begin failures++; $display("FAIL slow_timeout: got %0d timeouts want 0", to); end
    checks++; if (clr_cnt - c0 != 4) begin failures++; $display("FAIL slow_clr_rdy_count: got %0d want 4", clr_cnt - c0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL slow_done_count: got %0d want 1", done_cnt - d0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL slow_write: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL slow_write: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
    checks++; if (wr_log.size() != wr_rd) begin failures++; $display("FAIL slow_extra_writes: got %0d want %0d", wr_log.size(), wr_rd); wr_rd = wr_log.size(); end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w[$];
    int sc, to;
    bit ok1, ok2, ok3;
    wr_t e;
    exp_q.push_back({13'h100, 16'hC0DE});
    start = 1'b1; base_addr = 13'h100; word_cnt = 13'd3;
    fork
      begin
        @(posedge clk);
        #1 start = 1'b0;
      end
      begin
        send_byte(8'hC0, 0, ok1);
        send_byte(8'hDE, 0, ok2);
        send_byte(8'h99, 0, ok3);
      end
    join
    checks++; if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL rst_mid_bytes: got %b%b%b want 111", ok1, ok2, ok3); end
    rst_n = 1'b0; rx_data = 8'h77; rx_rdy = 1'b1;
    @(negedge clk);
    checks++; if (clr_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_clr_rdy: got %b want 0", clr_rdy); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got busy=%b stall=%b want 0/0", busy, cpu_stall); end
    rst_n = 1'b1; rx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    w.push_back(16'h5AA5);
    run_load(13'h200, 13'd1, w, 0, 1'b0, sc, to);
    checks++; if (to != 0) begin failures++; $display("FAIL rst_mid_reload_timeout: got %0d timeouts want 0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (wr_rd >= wr_log.size()) begin failures++; $display("FAIL rst_mid_write: got none want %h@%h", e.data, e.addr); end
      else begin
        if (wr_log[wr_rd] !== e) begin failures++; $display("FAIL rst_mid_write: got %h@%h want %h@%h", wr_log[wr_rd].data, wr_log[wr_rd].addr, e.data, e.addr); end
        wr_rd++;
      end
    end
    checks++; if (wr_log.size() != wr_rd) begin failures++; $display("FAIL rst_mid_extra_writes: got %0d want %0d", wr_log.size(), wr_rd); wr_rd = wr_log.size(); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
    rx_data = '0; rx_rdy = 1'b0;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wrt_data = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_cpu_write();
    test_stall();
    test_slow_uart();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dm_uart_loader
